// File: rtl/m6502_timer_irq_target.sv
// m6502_timer_irq_target: memory-mapped interrupt source for the cpu6502 bus.
// It provides a 16-bit down-counting interval timer (T1), a software interrupt
// (SWI), a flag register (IFR) and an enable register (IER). It drives the CPU's
// level irq input and, optionally, its nmi input.
// Optional feature: define M6502_TIMER_NMI_EN to make CTRL[1] writable. When
// CTRL[1] is 1, T1 is routed to nmi instead of irq. When the macro is not
// defined, CTRL[1] reads 0 and nmi is tied to 0.
module m6502_timer_irq_target #(
  parameter logic [15:0] BASE_ADDR = 16'hDC00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic        irq,
  output logic        nmi
);

  localparam logic [2:0] OFF_LATL = 3'd0;
  localparam logic [2:0] OFF_LATH = 3'd1;
  localparam logic [2:0] OFF_CNTL = 3'd2;
  localparam logic [2:0] OFF_CNTH = 3'd3;
  localparam logic [2:0] OFF_CTRL = 3'd4;
  localparam logic [2:0] OFF_IFR  = 3'd5;
  localparam logic [2:0] OFF_IER  = 3'd6;
  localparam logic [2:0] OFF_SWI  = 3'd7;

  logic [15:0] latch, latch_n;
  logic [15:0] cnt, cnt_n;
  logic        cont, cont_n;
  logic        route, route_n;
  logic [1:0]  ifr, ifr_n;
  logic [1:0]  ier, ier_n;
  logic        running, running_n;
  logic        irq_n, nmi_n;

  logic [2:0]  off;
  logic        wr, rd, underflow;

  assign off = address[2:0];
  assign hit = (address[15:3] == BASE_ADDR[15:3]);
  assign wr  = hit & write;
  assign rd  = hit & ~write;
  // The counter hits zero while running: this cycle's edge sets the T1 flag.
  assign underflow = running && (cnt == 16'h0000);

`ifdef M6502_TIMER_NMI_EN
  // The NMI route bit is a real register only when the feature is built in.
  always_ff @(posedge clk) begin
    if (reset) route <= 1'b0;
    else       route <= route_n;
  end
  assign route_n = (wr && off == OFF_CTRL) ? wdata[1] : route;
`else
  assign route   = 1'b0;
  assign route_n = 1'b0;
`endif

  // Next-state logic for the timer, the flags, the enables and the interrupt lines.
  always_comb begin
    latch_n   = latch;
    cnt_n     = cnt;
    cont_n    = cont;
    ifr_n     = ifr;
    ier_n     = ier;
    running_n = running;

    // The timer advances first. A LATH write below overrides it, because a write wins over a reload.
    if (running) begin
      if (cnt != 16'h0000) begin
        cnt_n = cnt - 16'd1;
      end else if (cont) begin
        cnt_n = latch;            // the reload uses the latch value from before the edge
      end else begin
        running_n = 1'b0;
      end
    end

    // Clearing IFR[0] (by an IFR write or a CNTL read) loses to a same-edge underflow.
    if (wr && off == OFF_IFR) begin
      ifr_n = ifr & ~wdata[1:0];
    end
    if (rd && off == OFF_CNTL) begin
      ifr_n[0] = 1'b0;
    end
    if (underflow) begin
      ifr_n[0] = 1'b1;
    end

    if (wr) begin
      case (off)
        OFF_LATL: latch_n[7:0] = wdata;
        OFF_LATH: begin
          latch_n[15:8] = wdata;
          cnt_n         = {wdata, latch[7:0]};
          running_n     = 1'b1;
          ifr_n[0]      = 1'b0;
        end
        OFF_CTRL: cont_n = wdata[0];
        OFF_IER:  ier_n  = wdata[7] ? (ier | wdata[1:0]) : (ier & ~wdata[1:0]);
        OFF_SWI:  ifr_n[1] = 1'b1;
        default:  ;
      endcase
    end

    // irq and nmi are registered, so they always match the flag state after the edge.
    irq_n = |(ifr_n & ier_n & {1'b1, ~route_n});
    nmi_n = ifr_n[0] & ier_n[0] & route_n;
  end

  // State register. Reset returns every register to its power-on value.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch   <= 16'h0000;
      cnt     <= 16'h0000;
      cont    <= 1'b0;
      ifr     <= 2'b00;
      ier     <= 2'b00;
      running <= 1'b0;
      irq     <= 1'b0;
      nmi     <= 1'b0;
    end else begin
      latch   <= latch_n;
      cnt     <= cnt_n;
      cont    <= cont_n;
      ifr     <= ifr_n;
      ier     <= ier_n;
      running <= running_n;
      irq     <= irq_n;
      nmi     <= nmi_n;
    end
  end

  // Combinational read mux. It returns 0 when the address is outside the window.
  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      case (off)
        OFF_LATL: rdata = latch[7:0];
        OFF_LATH: rdata = latch[15:8];
        OFF_CNTL: rdata = cnt[7:0];
        OFF_CNTH: rdata = cnt[15:8];
        OFF_CTRL: rdata = {6'b000000, route, cont};
        OFF_IFR:  rdata = {|(ifr & ier), 5'b00000, ifr};
        OFF_IER:  rdata = {1'b1, 5'b00000, ier};
        default:  rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_m6502_timer_irq_target.sv
// Directed bench for m6502_timer_irq_target. It covers register reset values,
// the one-shot and continuous timer, the SWI flag, the IER and IFR handling,
// same-edge priority cases and the optional NMI routing.
module tb_m6502_timer_irq_target;

  localparam logic [15:0] BASE = 16'hDC00;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        write;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        hit, irq, nmi;

  int checks = 0;
  int errors = 0;

  m6502_timer_irq_target #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .wdata(wdata),
    .rdata(rdata), .hit(hit), .irq(irq), .nmi(nmi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Performs one bus write cycle. The write takes effect at the next edge; afterwards the bus returns to idle.
  task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
    address = BASE + {13'd0, off};
    write   = 1'b1;
    wdata   = d;
    @(posedge clk);
    #1;
    address = 16'h0000;
    write   = 1'b0;
    wdata   = 8'h00;
  endtask

  // Performs one full read cycle, including its edge. This is needed for the CNTL-read clear.
  task automatic bus_read(input logic [2:0] off, output logic [7:0] d);
    address = BASE + {13'd0, off};
    write   = 1'b0;
    #1;
    d = rdata;
    @(posedge clk);
    #1;
    address = 16'h0000;
  endtask

  // Samples the combinational read data without letting an edge occur while the address is selected.
  task automatic peek(input logic [2:0] off, output logic [7:0] d);
    address = BASE + {13'd0, off};
    write   = 1'b0;
    #1;
    d = rdata;
    address = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] exp_rst [8];
    int events;
    exp_rst = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
    address = 16'h0000;
    write   = 1'b0;
    wdata   = 8'h00;
    do_reset();

    // Test 1: reset state.
    for (int i = 0; i < 8; i++) begin
      peek(3'(i), d);
      check_eq($sformatf("reset_reg%0d", i), {8'h00, d}, {8'h00, exp_rst[i]});
    end
    check_eq("reset_irq", {15'd0, irq}, 16'd0);
    check_eq("reset_nmi", {15'd0, nmi}, 16'd0);
    address = 16'h0000; #1;
    check_eq("hit_at_0000", {15'd0, hit}, 16'd0);
    address = BASE + 16'd5; #1;
    check_eq("hit_in_window", {15'd0, hit}, 16'd1);
    address = 16'h0000;

    // Test 2: one-shot timer, latch 0003. Underflow occurs exactly 4 edges after the LATH write.
    bus_write(3'd0, 8'h03);
    bus_write(3'd6, 8'h81);
    bus_write(3'd1, 8'h00);
    peek(3'd2, d);
    check_eq("t2_cnt_loaded", {8'h00, d}, 16'h0003);
    tick(3);
    check_eq("t2_irq_after3", {15'd0, irq}, 16'd0);
    tick(1);
    check_eq("t2_irq_after4", {15'd0, irq}, 16'd1);
    peek(3'd5, d);
    check_eq("t2_ifr", {8'h00, d}, 16'h0081);
    tick(3);
    peek(3'd2, d);
    check_eq("t2_cntl_hold", {8'h00, d}, 16'h0000);
    peek(3'd3, d);
    check_eq("t2_cnth_hold", {8'h00, d}, 16'h0000);
    check_eq("t2_irq_held", {15'd0, irq}, 16'd1);
    bus_read(3'd2, d);
    check_eq("t2_cntl_read_irq", {15'd0, irq}, 16'd0);
    peek(3'd5, d);
    check_eq("t2_cntl_read_ifr", {8'h00, d}, 16'h0000);

    // Test 3: continuous timer, latch 0002. The flag sets every 3 edges and is cleared by an IFR write.
    bus_write(3'd4, 8'h01);
    bus_write(3'd0, 8'h02);
    bus_write(3'd1, 8'h00);
    events = 0;
    for (int i = 0; i < 9; i++) begin
      if (irq) begin
        events++;
        bus_write(3'd5, 8'h01);
      end else begin
        tick(1);
      end
    end
    if (irq) events++;
    check_eq("t3_events_9cyc", 16'(events), 16'd3);
    peek(3'd2, d);
    check_eq("t3_cnt_reloaded", {8'h00, d}, 16'h0002);

    // Reset while the timer is counting: all state returns to its reset value and the timer stops.
    do_reset();
    peek(3'd2, d);
    check_eq("rst_mid_cnt", {8'h00, d}, 16'h0000);
    tick(5);
    peek(3'd2, d);
    check_eq("rst_mid_stopped", {8'h00, d}, 16'h0000);
    peek(3'd0, d);
    check_eq("rst_mid_latl", {8'h00, d}, 16'h0000);
    check_eq("rst_mid_irq", {15'd0, irq}, 16'd0);

    // Test 4: software interrupt with enable and clear.
    bus_write(3'd7, 8'h5A);
    peek(3'd5, d);
    check_eq("t4_swi_ifr", {8'h00, d}, 16'h0002);
    check_eq("t4_swi_irq_masked", {15'd0, irq}, 16'd0);
    bus_write(3'd6, 8'h82);
    check_eq("t4_ier_irq", {15'd0, irq}, 16'd1);
    peek(3'd5, d);
    check_eq("t4_ier_ifr", {8'h00, d}, 16'h0082);
    peek(3'd6, d);
    check_eq("t4_ier_read", {8'h00, d}, 16'h0082);
    bus_write(3'd5, 8'h02);
    check_eq("t4_clr_irq", {15'd0, irq}, 16'd0);
    peek(3'd5, d);
    check_eq("t4_clr_ifr", {8'h00, d}, 16'h0000);
    bus_write(3'd6, 8'h02);
    peek(3'd6, d);
    check_eq("t4_ier_clear", {8'h00, d}, 16'h0080);

    // Test 5: same-edge priority cases, using a continuous timer with latch 0002.
    do_reset();
    bus_write(3'd6, 8'h81);
    bus_write(3'd4, 8'h01);
    bus_write(3'd0, 8'h02);
    bus_write(3'd1, 8'h00);            // E0: cnt=2
    tick(3);                           // E3: underflow
    check_eq("t5_first_uf", {15'd0, irq}, 16'd1);
    tick(2);                           // E5
    bus_write(3'd5, 8'h01);            // E6: underflow coincides with the clear
    check_eq("t5_set_wins_irq", {15'd0, irq}, 16'd1);
    peek(3'd5, d);
    check_eq("t5_set_wins_ifr", {8'h00, d}, 16'h0081);
    bus_write(3'd0, 8'h05);            // E7: cnt 2->1
    tick(1);                           // E8: cnt 1->0
    bus_write(3'd1, 8'h00);            // E9: underflow coincides with the LATH write
    peek(3'd5, d);
    check_eq("t5_lath_wins_ifr", {8'h00, d}, 16'h0000);
    peek(3'd2, d);
    check_eq("t5_lath_wins_cntl", {8'h00, d}, 16'h0005);
    peek(3'd3, d);
    check_eq("t5_lath_wins_cnth", {8'h00, d}, 16'h0000);
    check_eq("t5_lath_wins_irq", {15'd0, irq}, 16'd0);

    // Test 6: optional NMI routing, latch 0001.
    do_reset();
    bus_write(3'd4, 8'h02);
    bus_write(3'd6, 8'h81);
    bus_write(3'd0, 8'h01);
    bus_write(3'd1, 8'h00);            // E0: cnt=1
    tick(1);
    check_eq("t6_pre_irq", {15'd0, irq}, 16'd0);
    check_eq("t6_pre_nmi", {15'd0, nmi}, 16'd0);
    tick(1);                           // E2: underflow
    peek(3'd5, d);
    check_eq("t6_ifr", {8'h00, d}, 16'h0081);
    peek(3'd4, d);
`ifdef M6502_TIMER_NMI_EN
    check_eq("t6_nmi", {15'd0, nmi}, 16'd1);
    check_eq("t6_irq", {15'd0, irq}, 16'd0);
    check_eq("t6_ctrl", {8'h00, d}, 16'h0002);
`else
    check_eq("t6_nmi", {15'd0, nmi}, 16'd0);
    check_eq("t6_irq", {15'd0, irq}, 16'd1);
    check_eq("t6_ctrl", {8'h00, d}, 16'h0000);
`endif

    // Latch 0000: underflow occurs on the first edge after the LATH write.
    do_reset();
    bus_write(3'd6, 8'h81);
    bus_write(3'd1, 8'h00);
    check_eq("t7_zero_pre", {15'd0, irq}, 16'd0);
    tick(1);
    check_eq("t7_zero_uf", {15'd0, irq}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
